// File: rtl/nios_system_pio_pkg.sv
// Shared constants for the Nios system PIO slaves: register offsets,
// edge-type encodings and the arm-counter helper.
package nios_system_pio_pkg;

  localparam logic [1:0] PIO_DATA_OFS    = 2'd0;
  localparam logic [1:0] PIO_RSVD_OFS    = 2'd1;
  localparam logic [1:0] PIO_IRQMASK_OFS = 2'd2;
  localparam logic [1:0] PIO_EDGECAP_OFS = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam logic [1:0] ARM_DONE = 2'd3;

  // Saturating count of clocks since reset release.
  function automatic logic [1:0] arm_step(input logic [1:0] arm);
    logic [1:0] nxt;
    if (arm == ARM_DONE) begin
      nxt = arm;
    end else begin
      nxt = arm + 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/nios_system_input_filter.sv
// Two-flop synchronizer per input bit, followed by an optional per-bit
// debounce filter enabled with NIOS_SYSTEM_MAZE_INPUT_DEBOUNCE_EN.
module nios_system_input_filter #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] in_s
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;

  // Synchronizer next-state.
  always_comb begin
    sync1_d = in_port;
    sync2_d = sync1_q;
  end

  // Synchronizer flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef NIOS_SYSTEM_MAZE_INPUT_DEBOUNCE_EN
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] filt_q, filt_d;

  // A bit flips only after disagreeing with the filtered value for
  // DEBOUNCE_CYCLES consecutive clocks; any agreement restarts the count.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]  = '0;
        filt_d[i] = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Debounce state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      filt_q <= filt_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign in_s = filt_q;
`else
  logic unused_debounce_s;
  assign unused_debounce_s = (DEBOUNCE_CYCLES > 0);
  assign in_s = sync2_q;
`endif

endmodule

// File: rtl/nios_system_maze_input.sv
// Avalon-MM input PIO: synchronized/filtered DATA, IRQMASK and sticky W1C
// EDGECAPTURE with a level irq. Debounce: NIOS_SYSTEM_MAZE_INPUT_DEBOUNCE_EN.
module nios_system_maze_input
  import nios_system_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] in_s;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [1:0]       arm_q, arm_d;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] clr_s;
  logic             wr_s;
  logic             armed_s;

  nios_system_input_filter #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_filter (
    .clk    (clk),
    .reset_n(reset_n),
    .in_port(in_port),
    .in_s   (in_s)
  );

  // Edge detect, bus write decode and register next-state.
  always_comb begin
    wr_s    = chipselect & ~write_n;
    armed_s = (arm_q == ARM_DONE);
    arm_d   = arm_step(arm_q);
    prev_d  = in_s;

    case (EDGE_TYPE)
      EDGE_FALL: edge_s = ~in_s & prev_q;
      EDGE_ANY:  edge_s = in_s ^ prev_q;
      default:   edge_s = in_s & ~prev_q;
    endcase

    if (wr_s && (address == PIO_IRQMASK_OFS)) begin
      irqmask_d = writedata[WIDTH-1:0];
    end else begin
      irqmask_d = irqmask_q;
    end

    if (wr_s && (address == PIO_EDGECAP_OFS)) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = '0;
    end

    // Set is applied after clear so a same-cycle edge survives the W1C.
    if (armed_s) begin
      edgecap_d = (edgecap_q & ~clr_s) | edge_s;
    end else begin
      edgecap_d = edgecap_q & ~clr_s;
    end
  end

  // Register file, edge history and arm counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q    <= '0;
      irqmask_q <= '0;
      edgecap_q <= '0;
      arm_q     <= 2'd0;
    end else begin
      prev_q    <= prev_d;
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
      arm_q     <= arm_d;
    end
  end

  // Zero-wait-state read mux, decoded from address alone.
  always_comb begin
    readdata = 32'd0;
    case (address)
      PIO_DATA_OFS:    readdata[WIDTH-1:0] = in_s;
      PIO_IRQMASK_OFS: readdata[WIDTH-1:0] = irqmask_q;
      PIO_EDGECAP_OFS: readdata[WIDTH-1:0] = edgecap_q;
      default:         readdata = 32'd0;
    endcase
  end

  assign irq = |(edgecap_q & irqmask_q);

  if (WIDTH < 32) begin : g_wdata_unused
    logic unused_wdata_s;
    assign unused_wdata_s = ^writedata[31:WIDTH];
  end

endmodule

// File: tb/tb_nios_system_maze_input.sv
// Bench for nios_system_maze_input: a rising-edge and an any-edge instance
// share one bus/input; a history-based reference model checks every cycle.
module tb_nios_system_maze_input;

  localparam int W  = 4;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] rd_rise, rd_any;
  logic        irq_rise, irq_any;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nios_system_maze_input #(.WIDTH(W), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_rise),
    .in_port(in_port), .irq(irq_rise)
  );

  nios_system_maze_input #(.WIDTH(W), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(DB)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_any),
    .in_port(in_port), .irq(irq_any)
  );

  // Reference model: raw_h[n] is in_port as sampled n edges ago (0 = this edge).
  logic [3:0] raw_h [8];
  logic [3:0] fm, pm, mask_m;
  logic [3:0] ec_rise_m, ec_any_m;
  int         k_m;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) raw_h[i] = 4'd0;
    fm = 4'd0; pm = 4'd0; mask_m = 4'd0;
    ec_rise_m = 4'd0; ec_any_m = 4'd0; k_m = 0;
  endtask

  task automatic model_edge();
    logic [3:0] new_f, clr;
    logic       armed, wr;
    for (int i = 7; i > 0; i--) raw_h[i] = raw_h[i-1];
    raw_h[0] = in_port;
`ifdef NIOS_SYSTEM_MAZE_INPUT_DEBOUNCE_EN
    new_f = fm;
    for (int b = 0; b < W; b++) begin
      logic differs;
      differs = 1'b1;
      for (int j = 2; j <= DB + 1; j++) if (raw_h[j][b] == fm[b]) differs = 1'b0;
      if (differs) new_f[b] = ~fm[b];
    end
`else
    new_f = raw_h[1];
`endif
    if (k_m < 100) k_m++;
    armed = (k_m >= 4);
    wr    = chipselect && !write_n;
    clr   = (wr && address == 2'd3) ? writedata[3:0] : 4'd0;
    ec_rise_m = (ec_rise_m & ~clr) | (armed ? (fm & ~pm) : 4'd0);
    ec_any_m  = (ec_any_m & ~clr)  | (armed ? (fm ^ pm)  : 4'd0);
    if (wr && address == 2'd2) mask_m = writedata[3:0];
    pm = fm;
    fm = new_f;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] e_rise, e_any;
    case (address)
      2'd0:    begin e_rise = {28'd0, fm};        e_any = {28'd0, fm};       end
      2'd2:    begin e_rise = {28'd0, mask_m};    e_any = {28'd0, mask_m};   end
      2'd3:    begin e_rise = {28'd0, ec_rise_m}; e_any = {28'd0, ec_any_m}; end
      default: begin e_rise = 32'd0;              e_any = 32'd0;             end
    endcase
    chk({tag, "_rd_rise"}, rd_rise, e_rise);
    chk({tag, "_rd_any"}, rd_any, e_any);
    chk({tag, "_irq_rise"}, {31'd0, irq_rise}, {31'd0, |(ec_rise_m & mask_m)});
    chk({tag, "_irq_any"}, {31'd0, irq_any}, {31'd0, |(ec_any_m & mask_m)});
  endtask

  task automatic bus(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
    address = a; chipselect = cs; write_n = wn; writedata = wd;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    if (reset_n) model_edge();
    @(negedge clk);
    check_model(tag);
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic [3:0]  inp;
    logic [31:0] rd;
    logic        irq;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Rising-edge instance, starting from a reset with all inputs held high.
    tbl[0]  = '{2'd0, 1'b0, 1'b1, 32'd0,          4'hF, 32'h0, 1'b0};
    tbl[1]  = '{2'd0, 1'b0, 1'b1, 32'd0,          4'hF, 32'hF, 1'b0};
    tbl[2]  = '{2'd3, 1'b0, 1'b1, 32'd0,          4'hF, 32'h0, 1'b0};
    tbl[3]  = '{2'd3, 1'b0, 1'b1, 32'd0,          4'hF, 32'h0, 1'b0};
    tbl[4]  = '{2'd0, 1'b0, 1'b1, 32'd0,          4'hF, 32'hF, 1'b0};
    tbl[5]  = '{2'd2, 1'b1, 1'b0, 32'h2,          4'hF, 32'h2, 1'b0};
    tbl[6]  = '{2'd3, 1'b0, 1'b1, 32'd0,          4'hD, 32'h0, 1'b0};
    tbl[7]  = '{2'd0, 1'b0, 1'b1, 32'd0,          4'hD, 32'hD, 1'b0};
    tbl[8]  = '{2'd3, 1'b0, 1'b1, 32'd0,          4'hF, 32'h0, 1'b0};
    tbl[9]  = '{2'd3, 1'b0, 1'b1, 32'd0,          4'hF, 32'h0, 1'b0};
    tbl[10] = '{2'd3, 1'b0, 1'b1, 32'd0,          4'hF, 32'h2, 1'b1};
    tbl[11] = '{2'd3, 1'b1, 1'b0, 32'h2,          4'hF, 32'h0, 1'b0};
    tbl[12] = '{2'd1, 1'b1, 1'b0, 32'hFFFF_FFFF,  4'hF, 32'h0, 1'b0};
    tbl[13] = '{2'd2, 1'b0, 1'b1, 32'd0,          4'hF, 32'h2, 1'b0};

    reset_n = 1'b0;
    in_port = 4'hF;
    bus(2'd0, 1'b0, 1'b1, 32'd0);
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_rd", rd_rise, 32'd0);
    chk("reset_irq", {31'd0, irq_rise}, 32'd0);
    reset_n = 1'b1;

`ifndef NIOS_SYSTEM_MAZE_INPUT_DEBOUNCE_EN
    for (int i = 0; i < 14; i++) begin
      bus(tbl[i].addr, tbl[i].cs, tbl[i].wn, tbl[i].wd);
      in_port = tbl[i].inp;
      cycle("tbl");
      chk($sformatf("tbl%0d_rd", i), rd_rise, tbl[i].rd);
      chk($sformatf("tbl%0d_irq", i), {31'd0, irq_rise}, {31'd0, tbl[i].irq});
    end
`else
    repeat (14) cycle("settle");
`endif

    // Any-edge: W1C of bit0 on the same edge that captures a new bit0 edge.
    bus(2'd0, 1'b0, 1'b1, 32'd0);
    in_port = 4'hE;
    repeat (DB + 2) cycle("w1c_pre");
`ifdef NIOS_SYSTEM_MAZE_INPUT_DEBOUNCE_EN
    bus(2'd3, 1'b1, 1'b0, 32'h1);
    cycle("w1c_race");
    bus(2'd3, 1'b0, 1'b1, 32'd0);
    cycle("w1c_race_read");
`else
    bus(2'd0, 1'b0, 1'b1, 32'd0);
    in_port = 4'hF;
    cycle("w1c_edge0");
    cycle("w1c_edge1");
    bus(2'd3, 1'b1, 1'b0, 32'h1);
    cycle("w1c_race");
`endif
    chk("w1c_set_wins", {31'd0, rd_any[0]}, 32'd1);
    bus(2'd3, 1'b1, 1'b0, 32'hF);
    cycle("w1c_plain");
    chk("w1c_cleared", rd_any, 32'd0);

    // Mask cleared while captures accumulate; then unmask.
    bus(2'd2, 1'b1, 1'b0, 32'd0);
    in_port = 4'h0;
    cycle("mask0");
    bus(2'd3, 1'b0, 1'b1, 32'd0);
    repeat (DB + 2) cycle("low");
    in_port = 4'hF;
    repeat (DB + 3) cycle("high");
    chk("pending_ec", rd_rise, 32'hF);
    chk("masked_irq", {31'd0, irq_rise}, 32'd0);
    bus(2'd2, 1'b1, 1'b0, 32'hF);
    cycle("unmask");
    chk("unmask_irq", {31'd0, irq_rise}, 32'd1);
    bus(2'd1, 1'b1, 1'b0, 32'hFFFF_FFFF);
    cycle("rsvd");
    chk("rsvd_rd", rd_rise, 32'd0);

    // Asynchronous reset mid-cycle clears state with no clock edge.
    bus(2'd3, 1'b0, 1'b1, 32'd0);
    #1;
    chk("pre_rst_ec", rd_rise, 32'hF);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_ec", rd_rise, 32'd0);
    chk("async_rst_irq", {31'd0, irq_rise}, 32'd0);
    chk("async_rst_irq_any", {31'd0, irq_any}, 32'd0);
    address = 2'd2;
    #1;
    chk("async_rst_mask", rd_rise, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    in_port = 4'h0;
    bus(2'd0, 1'b0, 1'b1, 32'd0);
    reset_n = 1'b1;
    repeat (8) cycle("post_rst");

`ifdef NIOS_SYSTEM_MAZE_INPUT_DEBOUNCE_EN
    // Short glitch is filtered; a longer pulse appears after 2 + DB edges.
    in_port = 4'h1;
    repeat (3) cycle("glitch");
    in_port = 4'h0;
    repeat (8) begin
      cycle("glitch_after");
      chk("glitch_data", rd_rise, 32'd0);
    end
    address = 2'd3;
    cycle("glitch_ec");
    chk("glitch_ec_any", rd_any, 32'd0);
    address = 2'd0;
    in_port = 4'h1;
    repeat (DB + 1) cycle("pulse");
    chk("pulse_data_early", rd_rise, 32'd0);
    cycle("pulse_last");
    chk("pulse_data", rd_rise, 32'd1);
    in_port = 4'h0;
    repeat (12) cycle("pulse_tail");
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) in_port = 4'($urandom);
      bus(2'($urandom), 1'($urandom), 1'($urandom), $urandom);
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nios_system_maze_input.md
# nios_system_maze_input

Avalon-MM slave parallel input port for the Nios II system: the input-direction counterpart to the system's output PIO registers. It synchronizes `WIDTH` asynchronous board inputs (maze push-buttons/switches), captures selected edges into a sticky register, and raises a maskable level interrupt to the CPU. It sits on the system interconnect as a zero-wait-state slave alongside the existing output PIOs.

## Interface
- `WIDTH`, 4: number of input bits (1..32).
- `EDGE_TYPE`, 0: edge captured per bit; 0 = rising, 1 = falling, 2 = any.
- `DEBOUNCE_CYCLES`, 50000: stable-cycle count for the debounce filter; used only when debounce is compiled in; must be ≥ 1.

Ports:
- `clk` input 1: system clock; the only clock.
- `reset_n` input 1: reset, asynchronous and active-low.
- `address` input 2: register word offset.
- `chipselect` input 1: slave select.
- `write_n` input 1: active-low write strobe.
- `writedata` input 32: write data.
- `readdata` output 32: read data; combinational, zero wait states.
- `in_port` input WIDTH: asynchronous external inputs.
- `irq` output 1: level interrupt, active-high.

## Operation
- Register map:
  - 0 DATA: RO, zero-extended synchronized (filtered) input value.
  - 1: reserved, reads 0, writes ignored.
  - 2 IRQMASK: RW, bits [WIDTH-1:0].
  - 3 EDGECAPTURE: RO sticky bits; writes are write-1-to-clear per bit.
- Bits above WIDTH-1 read 0 on every register. `readdata` is a function of `address` only (it does not depend on `chipselect`).
- A write occurs on `chipselect && !write_n`, taking effect at the next `clk` edge.
- Input path: a 2-flop synchronizer per bit, feeding the optional debounce filter, which produces `in_s`. A `prev` register holds `in_s` delayed by one cycle.
- Edge detect:
  - rise = in_s & ~prev
  - fall = ~in_s & prev
  - any = in_s ^ prev
  - `EDGE_TYPE` selects which of these is used.
- Arm counter (2 bits) after reset: edge detection is suppressed until the pipeline is filled, 3 cycles after `reset_n` rises. An input held high through reset therefore produces no capture.
- EDGECAPTURE[i] is set on a detected edge and cleared by a write to offset 3 with writedata[i] = 1. If set and clear occur in the same cycle, set wins.
- `irq` = |(EDGECAPTURE & IRQMASK), combinational from registers.
- Reset values: sync flops, `prev`, DATA, IRQMASK, EDGECAPTURE, arm counter, and debounce state all 0. `irq` = 0 and `readdata` = 0 at reset.

## Timing
- `in_port` change to DATA readable: 2 `clk` edges without debounce; 2 + `DEBOUNCE_CYCLES` edges with debounce.
- EDGECAPTURE bit sets 1 edge after DATA changes; `irq` asserts in the same cycle if masked in.
- A W1C write at edge N clears the bit and drops `irq` from edge N onward.
- An IRQMASK write updates `irq` in the cycle after the write edge.
- Asserting `reset_n` mid-operation clears all state immediately; pending captures are lost.
- Input pulses shorter than 1 `clk` period can be missed; this is not required to be captured.

## Configuration
- `NIOS_SYSTEM_MAZE_INPUT_DEBOUNCE_EN` defined:
  - Per-bit counter of width $clog2(DEBOUNCE_CYCLES+1).
  - `in_s[i]` updates only after the synchronized bit has differed from `in_s[i]` for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any return to equality resets that bit's counter to 0.
- Undefined: `in_s` = synchronizer output directly; no counters are instantiated.

## Structure
- Shared package `nios_system_pio_pkg`:
  - Register offset constants `PIO_DATA_OFS` = 0, `PIO_IRQMASK_OFS` = 2, `PIO_EDGECAP_OFS` = 3.
  - Edge-type constants `EDGE_RISE`, `EDGE_FALL`, `EDGE_ANY`.
- One sub-module, `nios_system_input_filter`: synchronizer plus optional debounce for a `WIDTH` vector. It outputs `in_s`. It takes `clk`/`reset_n`.
- The top level holds the register file, edge detect, arm counter, and read mux.

## Test plan
- Reset with `in_port` = 4'hF held: read DATA after 5 cycles gives 0x0000000F; EDGECAPTURE reads 0; `irq` = 0.
- `EDGE_TYPE` = 0, IRQMASK = 4'h2, `in_port` bit1 driven 0→1: EDGECAPTURE = 0x2 and `irq` = 1 on the 3rd edge after the change. Writing 0x2 to offset 3 drops `irq` next cycle.
- W1C clear on the same cycle as a new edge on bit0 (`EDGE_TYPE` = 2): bit0 remains 1.
- IRQMASK = 0 with captures pending: `irq` = 0. Writing IRQMASK = 0xF raises `irq` the following cycle. Reading offset 1 gives 0.
- Debounce compiled in, `DEBOUNCE_CYCLES` = 4: a 3-cycle glitch leaves DATA unchanged and no capture occurs; a 6-cycle pulse updates DATA after 2 + 4 edges.
- Assert `reset_n` while EDGECAPTURE = 0xF: EDGECAPTURE, IRQMASK, and `irq` are all 0 immediately, before any clock edge.
